// File: rtl/fifo_wr_packetizer.sv
// Write-side framing stage: buffers 32-bit source words into a packet, then emits
// length header, payload bytes (MSB first) and an 8-bit checksum into the byte FIFO.
module fifo_wr_packetizer #(
    parameter int MAX_LEN = 16
) (
    input  logic        clk_w,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_din,
    output logic        busy,
    output logic [7:0]  pkt_count
);
    localparam int AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int BW  = AW + 2;
    localparam int WCW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {COLLECT, HDR, PAYLOAD, CSUM} state_t;
    state_t state, state_nxt;

    logic [31:0]    buffer [MAX_LEN];
    logic [WCW-1:0] wcnt;
    logic [BW-1:0]  bidx;
    logic [7:0]     len;
    logic [7:0]     checksum;
    logic [31:0]    cur_word;
    logic [7:0]     cur_byte;
    logic           word_acc;
    logic           closing;
    logic           byte_acc;
    logic           last_byte;

    // A packet closes on s_last or when the buffer holds MAX_LEN words.
    assign word_acc  = s_valid && s_ready;
    assign closing   = word_acc && (s_last || wcnt == WCW'(MAX_LEN - 1));
    assign byte_acc  = fifo_wr_en;
    assign cur_word  = buffer[bidx[BW-1:2]];
    assign last_byte = (bidx[1:0] == 2'd3) && (8'(bidx[BW-1:2]) == len - 8'd1);

    always_comb begin
        cur_byte = cur_word[31:24];
        case (bidx[1:0])
            2'd0: cur_byte = cur_word[31:24];
            2'd1: cur_byte = cur_word[23:16];
            2'd2: cur_byte = cur_word[15:8];
            2'd3: cur_byte = cur_word[7:0];
            default: cur_byte = cur_word[31:24];
        endcase
    end

    always_ff @(posedge clk_w or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (closing)               state_nxt = HDR;
            HDR:     if (byte_acc)              state_nxt = PAYLOAD;
            PAYLOAD: if (byte_acc && last_byte) state_nxt = CSUM;
            CSUM:    if (byte_acc)              state_nxt = COLLECT;
            default:                            state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        s_ready    = (state == COLLECT) && !rst;
        busy       = (state != COLLECT);
        fifo_wr_en = 1'b0;
        fifo_din   = 8'h00;
        case (state)
            HDR: begin
                fifo_wr_en = !fifo_full;
                fifo_din   = len;
            end
            PAYLOAD: begin
                fifo_wr_en = !fifo_full;
                fifo_din   = cur_byte;
            end
            CSUM: begin
                fifo_wr_en = !fifo_full;
                fifo_din   = checksum;
            end
            default: begin
                fifo_wr_en = 1'b0;
                fifo_din   = 8'h00;
            end
        endcase
    end

    // Buffer contents need no reset: wcnt restarts at 0 and overwrites them.
    always_ff @(posedge clk_w) begin
        if (word_acc) buffer[wcnt[AW-1:0]] <= s_data;
    end

    always_ff @(posedge clk_w or posedge rst) begin
        if (rst) begin
            wcnt      <= '0;
            bidx      <= '0;
            len       <= 8'h00;
            checksum  <= 8'h00;
            pkt_count <= 8'h00;
        end else begin
            if (word_acc) begin
                wcnt <= wcnt + 1'b1;
                if (closing) len <= 8'(wcnt) + 8'd1;
            end
            if (state == PAYLOAD && byte_acc) begin
                bidx     <= bidx + 1'b1;
                checksum <= checksum + cur_byte;
            end
            if (state == CSUM && byte_acc) begin
                pkt_count <= pkt_count + 8'd1;
                wcnt      <= '0;
                bidx      <= '0;
                checksum  <= 8'h00;
            end
        end
    end
endmodule

// File: doc/fifo_wr_packetizer.md
# fifo_wr_packetizer

Write-side framing stage that sits directly upstream of the dual-clock byte FIFO, in the clk_w domain. It collects 32-bit words from a valid/ready source into a local word buffer. It then emits a framed byte stream into the FIFO write port: length header, payload bytes MSB-first, then an 8-bit checksum. It throttles on the FIFO's full flag, so no byte is ever written while the FIFO is full.

## Interface
- MAX_LEN, 16, maximum payload words per packet; legal range 1..255; buffer depth = MAX_LEN words
- clk_w  in  1  write-domain clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  source word valid
- s_ready  out  1  block can accept a word this cycle
- s_data  in  32  source word
- s_last  in  1  marks final word of a packet, qualified by s_valid && s_ready
- fifo_full  in  1  FIFO full flag, sampled combinationally
- fifo_wr_en  out  1  FIFO write strobe
- fifo_din  out  8  byte presented to FIFO
- busy  out  1  high in any state other than COLLECT
- pkt_count  out  8  count of fully emitted packets, wraps 255 -> 0

## Operation
- States: COLLECT, HDR, PAYLOAD, CSUM.
- COLLECT
  - s_ready = 1.
  - A word is accepted on each edge with s_valid && s_ready and stored at buffer[wcnt]; wcnt increments.
  - The packet closes when the accepted word has s_last = 1, or when it is word number MAX_LEN (forced close; the next word starts a new packet).
  - On close: len latched = wcnt + 1; transition to HDR.
- HDR: fifo_din = len[7:0].
- PAYLOAD
  - Byte index bidx runs 0..4*len-1.
  - fifo_din = byte (3 - bidx[1:0]) of buffer[bidx >> 2], i.e. bits [31:24] come out first.
  - Leaves to CSUM after byte 4*len-1 is accepted.
- CSUM
  - fifo_din = checksum, defined as the sum mod 256 of all payload bytes (the header is excluded).
  - When the checksum byte is accepted: pkt_count increments, wcnt/bidx/checksum clear, state goes to COLLECT.
- fifo_wr_en = (state in HDR, PAYLOAD, CSUM) && !fifo_full. This is combinational.
- A byte is accepted on any edge where fifo_wr_en = 1; state, bidx and the checksum advance only on acceptance.
- When fifo_full = 1, fifo_din holds its value and nothing advances.
- In COLLECT, fifo_wr_en = 0 and fifo_din = 0.
- The checksum accumulator adds each payload byte as it is accepted, 8-bit wrap-around.
- Outside COLLECT, s_ready = 0 and the source is fully back-pressured; words are never dropped.

## Timing
- Reset values: state COLLECT; s_ready 0 while rst is high, then 1 after release; fifo_wr_en 0; fifo_din 0; busy 0; pkt_count 0; wcnt, bidx, checksum 0.
- Reset mid-operation: asynchronous abort. Partial packet and buffered words are discarded. The FIFO shares rst, so no partial frame survives.
- After the closing word is accepted on edge T, the header is on fifo_din during cycle T+1.
- With fifo_full held low, an N-word packet is emitted in 4N+2 consecutive cycles.
- s_ready returns to 1 the cycle after the checksum byte is accepted. No bubble beyond that cycle.
- A single-cycle fifo_full pulse stalls exactly one cycle.
- If fifo_full is asserted in the same cycle as a candidate byte, that byte is not written and is re-presented next cycle.
- wcnt and bidx must be wide enough for MAX_LEN and 4*MAX_LEN respectively. len is 8 bits.

## Test plan
- Single word 0xA1B2C3D4 with s_last = 1, FIFO never full -> bytes 0x01, 0xA1, 0xB2, 0xC3, 0xD4, 0xEA on six consecutive cycles; pkt_count becomes 1.
- Word 0xFF010000 with s_last = 1 -> bytes 0x01, 0xFF, 0x01, 0x00, 0x00, 0x00 (checksum wraps to 0x00).
- Two-word packet with fifo_full high for 3 cycles during the 2nd payload byte -> fifo_wr_en low for those 3 cycles, fifo_din stable, no duplicate or lost byte; total 13 cycles; s_ready = 0 throughout emission.
- MAX_LEN = 4, five words streamed with no s_last:
  - First frame: header 0x04 plus 16 payload bytes.
  - The fifth word starts a second packet, closed by s_last -> header 0x01.
- rst asserted mid-PAYLOAD -> fifo_wr_en and fifo_din go to 0 immediately. After release: pkt_count 0, s_ready 1, and the next packet is framed correctly from its header.
- 256 back-to-back single-word packets -> pkt_count wraps to 0x00 after the 256th checksum byte, and every frame is correct.
